// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, STATUS/CTRL registers, optional level irq.
// Define UART_MMIO_IRQ_EN to implement CTRL interrupt enables and the registered irq output.
module uart_mmio #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic [7:0]      tx_data,
  output logic            tx_data_valid,
  input  logic            tx_data_ack,
  input  logic [7:0]      rx_data,
  input  logic            rx_data_fresh,
  output logic            irq
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FullCnt = Depth[FIFO_AW:0];
  localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CntOne  = (FIFO_AW + 1)'(1);

  logic [7:0]         tx_mem_q [Depth];
  logic [7:0]         rx_mem_q [Depth];
  logic [FIFO_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [FIFO_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

  logic wr_data, wr_status, wr_ctrl, rd_data, flush;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_ovf_set, rx_push, rx_pop, rx_ovf_set;
  logic [31:0] status, ctrl_rd;
  logic [3:0]  tx_cnt4, rx_cnt4;
  logic [7:0]  rx_head;
  logic        unused_bits;

  assign wr_data   = sel & wr_en & (addr == 2'd0);
  assign wr_status = sel & wr_en & (addr == 2'd1);
  assign wr_ctrl   = sel & wr_en & (addr == 2'd2);
  assign rd_data   = sel & rd_en & (addr == 2'd0);
  assign flush     = wr_ctrl & wdata[2];

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);

  // A full FIFO still accepts a push when the same cycle pops it.
  assign tx_pop     = tx_data_ack & ~tx_empty;
  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_push    = rx_data_fresh & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_data_fresh & rx_full & ~rx_pop;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PtrOne;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PtrOne;
      if (rx_push) rx_wptr_d = rx_wptr_q + PtrOne;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PtrOne;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CntOne;
        2'b01:   tx_cnt_d = tx_cnt_q - CntOne;
        default: tx_cnt_d = tx_cnt_q;
      endcase
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CntOne;
        2'b01:   rx_cnt_d = rx_cnt_q - CntOne;
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
    // Set beats a same-cycle write-one-to-clear.
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~(wr_status & wdata[3]));
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(wr_status & wdata[4]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      if (tx_push && !flush) tx_mem_q[tx_wptr_q] <= wdata[7:0];
      if (rx_push && !flush) rx_mem_q[rx_wptr_q] <= rx_data;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  assign tx_data       = tx_mem_q[tx_rptr_q];
  assign tx_data_valid = ~tx_empty;

`ifdef UART_MMIO_IRQ_EN
  logic rx_ie_q, tx_ie_q, irq_q, irq_d;

  always_comb begin
    irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) |
            ((rx_ie_q | tx_ie_q) & (rx_ovf_q | tx_ovf_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_ie_q <= wdata[0];
        tx_ie_q <= wdata[1];
      end
      irq_q <= irq_d;
    end
  end

  assign ctrl_rd = {30'h0, tx_ie_q, rx_ie_q};
  assign irq     = irq_q;
`else
  assign ctrl_rd = 32'h0;
  assign irq     = 1'b0;
`endif

  assign tx_cnt4 = 4'(tx_cnt_q);
  assign rx_cnt4 = 4'(rx_cnt_q);
  assign status  = {12'h0, tx_cnt4, 4'h0, rx_cnt4, 3'h0,
                    tx_ovf_q, rx_ovf_q, tx_empty, tx_full, ~rx_empty};
  assign rx_head = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (addr)
        2'd0:    rdata = XLEN'(rx_head);
        2'd1:    rdata = XLEN'(status);
        2'd2:    rdata = XLEN'(ctrl_rd);
        default: rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^wdata[XLEN-1:8];

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: expected bus reads and TX handshakes are queued by the
// stimulus and checked by an independent monitor when the DUT presents them.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ack = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_data_fresh = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  uart_mmio #(.FIFO_AW(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ack(tx_data_ack), .rx_data(rx_data), .rx_data_fresh(rx_data_fresh), .irq(irq)
  );

`ifdef UART_MMIO_IRQ_EN
  localparam logic IrqOn = 1'b1;
`else
  localparam logic IrqOn = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [7:0]  tx_exp_q [$];
  logic [31:0] mon_exp;
  string       mon_name;
  logic [7:0]  mon_tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (rst && sel && rd_en) begin
      n_vec++;
      if (rd_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h, required no read", rdata);
      end else begin
        mon_exp  = rd_exp_q.pop_front();
        mon_name = rd_name_q.pop_front();
        if (rdata !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", mon_name, rdata, mon_exp);
        end
      end
    end
    if (rst && tx_data_ack && tx_data_valid) begin
      n_vec++;
      if (tx_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_tx: got 0x%02h, required no byte", tx_data);
      end else begin
        mon_tx = tx_exp_q.pop_front();
        if (tx_data !== mon_tx) begin
          n_bad++;
          $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, mon_tx);
        end
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; addr = a; wr_en = 1'b1; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr_en = 1'b0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    sel = 1'b1; addr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_data_fresh = 1'b1;
    @(posedge clk); #1;
    rx_data_fresh = 1'b0;
  endtask

  task automatic ack_pulse();
    tx_data_ack = 1'b1;
    @(posedge clk); #1;
    tx_data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_held", {31'h0, tx_data_valid}, 32'h0);
    rst = 1'b1;
    idle(1);
    bus_read(2'd1, 32'h0000_0004, "reset_status");
    check("reset_valid", {31'h0, tx_data_valid}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);

    // TX ordering
    bus_write(2'd0, 32'h41);
    bus_write(2'd0, 32'h42);
    bus_write(2'd0, 32'h43);
    check("tx_valid_after_write", {31'h0, tx_data_valid}, 32'h1);
    check("tx_head", {24'h0, tx_data}, 32'h41);
    bus_read(2'd1, 32'h0003_0000, "tx_status_3");
    tx_exp_q.push_back(8'h41);
    tx_exp_q.push_back(8'h42);
    tx_exp_q.push_back(8'h43);
    repeat (3) ack_pulse();
    check("tx_valid_drained", {31'h0, tx_data_valid}, 32'h0);
    ack_pulse();  // ack while empty: ignored
    bus_read(2'd1, 32'h0000_0004, "tx_ack_empty_status");

    // TX overflow
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd1, 32'h0008_0012, "tx_ovf_status");
    bus_write(2'd1, 32'h10);
    bus_read(2'd1, 32'h0008_0002, "tx_ovf_cleared");
    for (int i = 0; i < 8; i++) tx_exp_q.push_back(8'(i));
    repeat (8) ack_pulse();
    check("tx_valid_after_ovf_drain", {31'h0, tx_data_valid}, 32'h0);
    bus_read(2'd1, 32'h0000_0004, "tx_empty_status");

    // RX full boundary
    for (int i = 0; i < 8; i++) rx_pulse(8'(8'h10 + i));
    bus_read(2'd1, 32'h0000_0805, "rx_full_status");
    rd_exp_q.push_back(32'h10);
    rd_name_q.push_back("rx_pop_push_full");
    sel = 1'b1; addr = 2'd0; rd_en = 1'b1; rx_data = 8'h18; rx_data_fresh = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; rd_en = 1'b0; rx_data_fresh = 1'b0;
    bus_read(2'd1, 32'h0000_0805, "rx_no_ovf_status");
    for (int i = 1; i < 9; i++) bus_read(2'd0, 32'h10 + 32'(i), "rx_drain");
    bus_read(2'd0, 32'h0, "rx_empty_read");
    bus_read(2'd1, 32'h0000_0004, "rx_empty_status");
    rx_pulse(8'h5A);
    bus_read(2'd0, 32'h5A, "rx_after_empty");

    // RX overflow, then w1c
    for (int i = 0; i < 9; i++) rx_pulse(8'(8'h60 + i));
    bus_read(2'd1, 32'h0000_080D, "rx_ovf_status");
    bus_write(2'd1, 32'h08);
    bus_read(2'd1, 32'h0000_0805, "rx_ovf_cleared");
    bus_read(2'd0, 32'h60, "rx_ovf_head");

    // Flush both FIFOs
    bus_write(2'd0, 32'h99);
    bus_write(2'd0, 32'h98);
    bus_read(2'd1, 32'h0002_0701, "pre_flush_status");
    bus_write(2'd2, 32'h4);
    bus_read(2'd1, 32'h0000_0004, "post_flush_status");
    check("flush_valid", {31'h0, tx_data_valid}, 32'h0);
    bus_read(2'd0, 32'h0, "flush_rx_read");

    // Reserved and CTRL
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'h0, "reserved_read");
    bus_read(2'd1, 32'h0000_0004, "reserved_no_effect");
    bus_write(2'd2, 32'hFFFF_FFFB);
    bus_read(2'd2, IrqOn ? 32'h3 : 32'h0, "ctrl_read");
    bus_write(2'd2, 32'h0);
    idle(1);
    check("irq_ctrl_cleared", {31'h0, irq}, 32'h0);

    // IRQ on RX
    bus_write(2'd2, 32'h1);
    rx_pulse(8'h33);
    check("irq_not_early", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_rx", {31'h0, irq}, {31'h0, IrqOn});
    bus_read(2'd0, 32'h33, "irq_rx_read");
    idle(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h0);

    // Asynchronous reset mid-transfer
    bus_write(2'd0, 32'h77);
    check("pre_reset_valid", {31'h0, tx_data_valid}, 32'h1);
    check("pre_reset_data", {24'h0, tx_data}, 32'h77);
    #2 rst = 1'b0;
    #1;
    check("async_reset_valid", {31'h0, tx_data_valid}, 32'h0);
    check("async_reset_data", {24'h0, tx_data}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_read(2'd1, 32'h0000_0004, "post_reset_status");

    idle(2);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
